// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: memory stage moving 32-bit words to/from a 16-bit SRAM as two half-word phases.
module mem_stage_sram_ctrl #(
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] ALU_result,
   input  logic [31:0] ST_val,
   output logic [31:0] MEM_result,
   output logic        ready,
   output logic [17:0] SRAM_ADDR,
   output logic [15:0] SRAM_DQ_out,
   output logic        SRAM_DQ_oe,
   input  logic [15:0] SRAM_DQ_in,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);
   localparam logic [1:0] IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3;
   logic [1:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [16:0] addr_q, addr_d;
   logic [31:0] st_q, st_d, result_q, result_d;
   logic [15:0] lo_q, lo_d;
   logic [31:0] a;
   logic        req, last, active, unused_bits;
   assign req         = MEM_R_EN | MEM_W_EN;
   assign a           = ALU_result - BASE_ADDR;
   assign unused_bits = ^{a[31:19], a[1:0]};
   assign last        = cnt_q == 3'(WAIT_CYCLES);
   assign active      = state_q == LO || state_q == HI;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      st_d     = st_q;
      lo_d     = lo_q;
      result_d = result_q;
      case (state_q)
         IDLE: if (req) begin
            state_d = LO;
            cnt_d   = '0;
            wr_d    = MEM_W_EN;
            addr_d  = a[18:2];
            st_d    = ST_val;
         end
         LO: begin
            state_d = last ? HI : LO;
            cnt_d   = last ? 3'd0 : cnt_q + 3'd1;
            lo_d    = last ? SRAM_DQ_in : lo_q;
         end
         HI: begin
            state_d  = last ? DONE : HI;
            cnt_d    = last ? 3'd0 : cnt_q + 3'd1;
            result_d = (last && !wr_q) ? {SRAM_DQ_in, lo_q} : result_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         st_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         st_q     <= st_d;
         lo_q     <= lo_d;
         result_q <= result_d;
      end
   end
   // SRAM controls decode straight from state so reset releases them without a clock edge
   assign ready       = state_q == IDLE ? ~req : state_q == DONE;
   assign MEM_result  = result_q;
   assign SRAM_CE_N   = ~active;
   assign SRAM_UB_N   = ~active;
   assign SRAM_LB_N   = ~active;
   assign SRAM_OE_N   = ~(active & ~wr_q);
   assign SRAM_WE_N   = ~(active & wr_q);
   assign SRAM_DQ_oe  = active & wr_q;
   assign SRAM_ADDR   = active ? {addr_q, state_q == HI} : 18'd0;
   assign SRAM_DQ_out = state_q == LO ? st_q[15:0] : state_q == HI ? st_q[31:16] : 16'd0;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: randomized scoreboard bench with word-level reference memory and half-word SRAM model.
module tb_mem_stage_sram_ctrl;
   localparam int W = 1;
   logic clk = 1'b0, rst = 1'b1;
   logic mem_r = 1'b0, mem_w = 1'b0;
   logic [31:0] alu_i = '0, st_i = '0;
   logic [31:0] mem_result;
   logic ready, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
   logic [17:0] sram_addr;
   logic [15:0] dq_out, dq_in;
   logic [15:0] sram [32] = '{default: 16'h0};
   typedef struct packed {
      bit          wr;
      logic [3:0]  idx;
      logic [31:0] st;
      logic [31:0] res;
   } exp_t;
   exp_t sb[$];
   logic [31:0] ref_mem [16] = '{default: 32'h0};
   logic [31:0] last_rd = '0;
   int checks = 0, failures = 0;
   int gap = 0;

   mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
      .clk(clk), .rst(rst), .MEM_R_EN(mem_r), .MEM_W_EN(mem_w),
      .ALU_result(alu_i), .ST_val(st_i), .MEM_result(mem_result), .ready(ready),
      .SRAM_ADDR(sram_addr), .SRAM_DQ_out(dq_out), .SRAM_DQ_oe(dq_oe), .SRAM_DQ_in(dq_in),
      .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (!ce_n && !we_n) sram[sram_addr[4:0]] <= dq_out;
   assign dq_in = sram[sram_addr[4:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic issue(input bit r, input bit w, input logic [3:0] idx, input logic [31:0] st);
      exp_t e;
      int n;
      e.wr = w;
      e.idx = idx;
      e.st = st;
      if (w) ref_mem[idx] = st;
      else last_rd = ref_mem[idx];
      e.res = last_rd;
      sb.push_back(e);
      mem_r = r;
      mem_w = w;
      alu_i = 32'd1024 + {26'd0, idx, 2'b00} + 32'($urandom_range(0, 3));
      st_i = st;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ready === 1'b1 && n > 1) && n < 64);
      if (!(ready === 1'b1 && n > 1)) begin
         checks++;
         failures++;
         $display("FAIL timeout: ready never returned after %0d cycles", n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      mem_r = 1'b0;
      mem_w = 1'b0;
      alu_i = $urandom;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // monitor: tallies SRAM activity per transaction and scores it when ready rises
   initial begin
      int low, wlo, whi, rlo, rhi, bad, cyc, last_done;
      bit prev_rdy;
      exp_t e;
      logic [17:0] lo_a;
      low = 0; wlo = 0; whi = 0; rlo = 0; rhi = 0; bad = 0; cyc = 0; last_done = 0;
      prev_rdy = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            low = 0; wlo = 0; whi = 0; rlo = 0; rhi = 0; bad = 0;
            prev_rdy = 1'b1;
         end else begin
            if (!ready) low++;
            if (ce_n) begin
               if (!(oe_n && we_n && ub_n && lb_n && !dq_oe)) bad++;
            end else if (sb.size() == 0) bad++;
            else begin
               e = sb[0];
               lo_a = 18'(e.idx) * 18'd2;
               if (!we_n && oe_n && dq_oe && !ub_n && !lb_n) begin
                  if (sram_addr == lo_a && dq_out == e.st[15:0]) wlo++;
                  else if (sram_addr == lo_a + 18'd1 && dq_out == e.st[31:16]) whi++;
                  else bad++;
               end else if (!oe_n && we_n && !dq_oe && !ub_n && !lb_n) begin
                  if (sram_addr == lo_a) rlo++;
                  else if (sram_addr == lo_a + 18'd1) rhi++;
                  else bad++;
               end else bad++;
            end
            if (ready && !prev_rdy) begin
               gap = cyc - last_done;
               last_done = cyc;
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_done: completion with empty scoreboard");
               end else begin
                  e = sb.pop_front();
                  chk("mem_result", mem_result, e.res);
                  chk("low_cycles", 32'(low), 32'(2 * W + 3));
                  chk("half_lo", 32'(e.wr ? wlo : rlo), 32'(W + 1));
                  chk("half_hi", 32'(e.wr ? whi : rhi), 32'(W + 1));
                  chk("wrong_dir", 32'(e.wr ? rlo + rhi : wlo + whi), 32'd0);
                  chk("bad_cycles", 32'(bad), 32'd0);
               end
               low = 0; wlo = 0; whi = 0; rlo = 0; rhi = 0; bad = 0;
            end
            prev_rdy = ready;
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_ctrl_n", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1f);
      chk("rst_result", mem_result, 32'd0);
      chk("rst_dq_oe", 32'(dq_oe), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      @(posedge clk);
      #1;
      issue(1'b0, 1'b1, 4'd2, 32'hDEAD_BEEF);
      idle(2);
      issue(1'b1, 1'b0, 4'd2, $urandom);
      chk("load_beef", mem_result, 32'hDEAD_BEEF);
      issue(1'b0, 1'b1, 4'd0, 32'h1234_5678);
      issue(1'b1, 1'b0, 4'd0, $urandom);
      chk("b2b_result", mem_result, 32'h1234_5678);
      chk("b2b_gap", 32'(gap), 32'(2 * W + 4));
      issue(1'b0, 1'b1, 4'd3, 32'hA5A5_A5A5);
      issue(1'b1, 1'b0, 4'd3, $urandom);
      issue(1'b1, 1'b1, 4'd4, 32'h0BAD_F00D);
      chk("both_keeps", mem_result, 32'hA5A5_A5A5);
      issue(1'b1, 1'b0, 4'd4, $urandom);
      chk("both_wrote", mem_result, 32'h0BAD_F00D);
      for (int i = 0; i < 60; i++) begin
         int op;
         op = int'($urandom_range(0, 2));
         issue(op != 1, op != 0, 4'($urandom_range(0, 14)), $urandom);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      mem_r = 1'b0;
      mem_w = 1'b1;
      alu_i = 32'd1024 + 32'd60;
      st_i = $urandom;
      repeat (W + 2) @(posedge clk);
      #2;
      chk("abort_in_hi_write", 32'({sram_addr[0], we_n}), 32'h2);
      rst = 1'b1;
      #1;
      chk("abort_we_n", 32'(we_n), 32'd1);
      chk("abort_dq_oe", 32'(dq_oe), 32'd0);
      chk("abort_ce_n", 32'(ce_n), 32'd1);
      mem_w = 1'b0;
      @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      issue(1'b1, 1'b0, 4'd0, $urandom);
      chk("post_rst_load", mem_result, 32'h1234_5678 == ref_mem[0] ? 32'h1234_5678 : ref_mem[0]);
      idle(3);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory stage that consumes the EXE/MEM pipeline register outputs (MEM_R_EN, MEM_W_EN, ALU_result, ST_val).
- Performs 32-bit data loads and stores to an external 16-bit SRAM, as two half-word accesses per word.
- Drives `ready` low while an access is in flight. The top level inverts `ready` into the `freeze` input of all upstream pipeline registers.
- Sits between the EXE/MEM register and the MEM/WB register.

Parameters:
- WAIT_CYCLES, 1, extra SRAM cycles per half-word access. Each half-word phase lasts WAIT_CYCLES+1 cycles. Legal range 0..7.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- MEM_R_EN  in  1  load request (from EXE/MEM register)
- MEM_W_EN  in  1  store request (from EXE/MEM register)
- ALU_result  in  32  byte address
- ST_val  in  32  store data (Rm value)
- MEM_result  out  32  last loaded word
- ready  out  1  1 = stage can advance; 0 = freeze pipeline
- SRAM_ADDR  out  18  half-word address
- SRAM_DQ_out  out  16  write data
- SRAM_DQ_oe  out  1  1 = drive SRAM_DQ (the top level instantiates the tristate)
- SRAM_DQ_in  in  16  read data
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - FSM = IDLE, phase counter = 0, MEM_result = 0.
  - SRAM_ADDR = 0, SRAM_DQ_out = 0, SRAM_DQ_oe = 0.
  - All SRAM_*_N = 1.
- Request decode: req = MEM_R_EN | MEM_W_EN.
  - If both enables are high, the access is a write; MEM_result is unchanged.
- Address mapping: a = ALU_result - BASE_ADDR (32-bit wrap).
  - Low half-word: SRAM_ADDR = {a[18:2], 1'b0}.
  - High half-word: SRAM_ADDR = {a[18:2], 1'b1}.
  - a[1:0] is ignored, since only aligned words are accessed.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if req, go to LO and latch the operation type (rd/wr), word address and ST_val; counter = 0. Otherwise stay in IDLE.
  - LO: counter counts 0..WAIT_CYCLES; at WAIT_CYCLES go to HI and clear counter.
  - HI: same counting; at WAIT_CYCLES go to DONE.
  - DONE: always go to IDLE after one cycle.
- ready (combinational):
  - IDLE: ready = ~req.
  - LO, HI: ready = 0.
  - DONE: ready = 1.
- Latency: a request first seen at cycle 0 gives ready = 0 for cycles 0 .. 2*WAIT_CYCLES+2 and ready = 1 at cycle 2*WAIT_CYCLES+3. For WAIT_CYCLES=1 that is 5 low cycles, then high.
- SRAM signals in LO/HI:
  - SRAM_CE_N = 0, SRAM_UB_N = 0, SRAM_LB_N = 0.
  - Read: SRAM_OE_N = 0, SRAM_WE_N = 1, SRAM_DQ_oe = 0.
  - Write: SRAM_WE_N = 0, SRAM_OE_N = 1, SRAM_DQ_oe = 1.
  - SRAM_DQ_out = latched ST_val[15:0] in LO, ST_val[31:16] in HI.
- SRAM signals in IDLE/DONE: all _N = 1, SRAM_DQ_oe = 0.
- Read capture:
  - On the last cycle of LO (counter == WAIT_CYCLES), SRAM_DQ_in is latched into a low-half holding register.
  - On the last cycle of HI, MEM_result <= {SRAM_DQ_in, low_half}.
  - MEM_result is stable from DONE onward and holds until the next read completes. Writes never change it.
- Operands are latched at IDLE→LO. Changes on ALU_result/ST_val during LO/HI are ignored; the upstream pipeline is frozen in any case.
- In DONE the inputs still carry the same instruction. Because the FSM returns to IDLE unconditionally, the access is not re-issued. The next IDLE cycle sees the following instruction.
- Back-to-back requests: an access can start in the cycle immediately after DONE. There is no dead cycle beyond IDLE evaluation.
- Reset mid-access: the FSM aborts immediately to IDLE and controls deassert asynchronously. A partially written word is not recovered.

Test Plan:
- Reset then idle, no requests: ready = 1, all SRAM_*_N = 1, MEM_result = 0, SRAM_DQ_oe = 0.
- Store, WAIT_CYCLES=1, ALU_result=1032, ST_val=32'hDEAD_BEEF:
  - SRAM_ADDR = 4 with DQ = 16'hBEEF and WE_N low for 2 cycles.
  - Then SRAM_ADDR = 5 with DQ = 16'hDEAD for 2 cycles.
  - ready low for 5 cycles, then high for 1 cycle.
- Load from 1032, with an SRAM model returning the stored data: MEM_result = 32'hDEADBEEF in DONE. OE_N is low only during LO/HI, and DQ_oe = 0 throughout.
- Back-to-back store to 1024 then load from 1024 (ST_val=32'h1234_5678): the load starts the cycle after the store's DONE and returns 32'h12345678. Two ready pulses are 6 cycles apart.
- MEM_R_EN and MEM_W_EN both 1 with MEM_result previously 32'hA5A5A5A5: a write is performed and MEM_result stays 32'hA5A5A5A5.
- rst asserted in the HI phase of a write: FSM = IDLE, WE_N = 1 and DQ_oe = 0 with no clock edge; after release, ready = 1 and a new load completes normally.
